// File: rtl/dma_chan_sched.sv
// Round-robin scheduler sharing one DMA engine between NUM_CH channels.
// Queues one descriptor per channel, launches it and routes done/error back to the owner.
package dma_pkg;
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] bytes;
    } s_dma_desc_t;

    typedef struct packed {
        logic done;
        logic error;
    } s_dma_status_t;

    typedef enum logic [0:0] {
        ERR_SRC_RD = 1'b0,
        ERR_SRC_WR = 1'b1
    } e_err_src_t;

    typedef struct packed {
        logic       valid;
        logic [31:0] addr;
        e_err_src_t src;
    } s_dma_error_t;
endpackage

module dma_chan_sched
    import dma_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 65535,
    localparam int CW = $clog2(NUM_CH),
    localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   ch_go_i,
    input  s_dma_desc_t         ch_desc_i [NUM_CH],
    input  logic [NUM_CH-1:0]   ch_en_i,
    output logic [NUM_CH-1:0]   ch_pend_o,
    output logic [NUM_CH-1:0]   ch_busy_o,
    output logic [NUM_CH-1:0]   ch_done_o,
    output logic [NUM_CH-1:0]   ch_err_o,
    output logic [NUM_CH-1:0]   ch_reject_o,
    output s_dma_error_t        err_info_o,
    output logic [CW-1:0]       err_ch_o,
    output logic                timeout_o,
    output logic                dma_go_o,
    output s_dma_desc_t         dma_desc_o,
    input  s_dma_status_t       dma_stats_i,
    input  s_dma_error_t        dma_error_i
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    localparam logic [TW-1:0] T_LIM  = TW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] CH_MAX = CW'(NUM_CH - 1);

    state_t             state_q, state_d;
    s_dma_desc_t        desc_q [NUM_CH];
    s_dma_desc_t        desc_d [NUM_CH];
    logic [NUM_CH-1:0]  pend_q, pend_d;
    logic [NUM_CH-1:0]  busy_q, busy_d;
    logic [NUM_CH-1:0]  done_q, done_d;
    logic [NUM_CH-1:0]  err_q, err_d;
    logic [NUM_CH-1:0]  reject_q, reject_d;
    s_dma_error_t       err_info_q, err_info_d;
    logic [CW-1:0]      err_ch_q, err_ch_d;
    logic               timeout_q, timeout_d;
    logic               dma_go_q, dma_go_d;
    s_dma_desc_t        dma_desc_q, dma_desc_d;
    logic [CW-1:0]      last_q, last_d;
    logic [CW-1:0]      cur_q, cur_d;
    logic [TW-1:0]      cnt_q, cnt_d;
    logic [NUM_CH-1:0]  req_s;
    logic [CW-1:0]      pick_s;

    // First requesting channel after 'last', wrapping around.
    function automatic logic [CW-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CW-1:0]     last);
        logic          found;
        logic [CW-1:0] sel;
        logic [CW-1:0] idx_c;
        int            idx;
        found = 1'b0;
        sel   = last;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx   = (int'(last) + k) % NUM_CH;
            idx_c = CW'(idx);
            if (!found && req[idx_c]) begin
                found = 1'b1;
                sel   = idx_c;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    // Next-state logic: descriptor capture, arbitration and transfer sequencing.
    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        pend_d     = pend_q;
        busy_d     = busy_q;
        done_d     = '0;
        err_d      = '0;
        reject_d   = '0;
        err_info_d = err_info_q;
        err_ch_d   = err_ch_q;
        timeout_d  = timeout_q;
        dma_go_d   = 1'b0;
        dma_desc_d = dma_desc_q;
        last_d     = last_q;
        cur_d      = cur_q;
        cnt_d      = cnt_q;
        req_s      = pend_q & ch_en_i;
        pick_s     = rr_pick(req_s, last_q);

        // Busy stays high through the done/err pulse, so a go in that cycle is rejected.
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_go_i[i] && !pend_q[i] && !busy_q[i]) begin
                pend_d[i] = 1'b1;
                desc_d[i] = ch_desc_i[i];
            end else begin
                reject_d[i] = ch_go_i[i];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (|req_s) begin
                    cur_d          = pick_s;
                    dma_desc_d     = desc_q[pick_s];
                    pend_d[pick_s] = 1'b0;
                    busy_d[pick_s] = 1'b1;
                    timeout_d      = 1'b0;
                    state_d        = S_LAUNCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                dma_go_d = 1'b1;
                cnt_d    = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if ((TIMEOUT_CYC != 0) && (cnt_q < T_LIM)) begin
                    cnt_d = cnt_q + TW'(1);
                end else begin
                    cnt_d = cnt_q;
                end
                if ((TIMEOUT_CYC != 0) && (cnt_d == T_LIM)) begin
                    timeout_d = 1'b1;
                end else begin
                    timeout_d = timeout_q;
                end
                if (dma_stats_i.error || dma_error_i.valid) begin
                    err_info_d   = dma_error_i;
                    err_ch_d     = cur_q;
                    err_d[cur_q] = 1'b1;
                    state_d      = S_FINISH;
                end else if (dma_stats_i.done) begin
                    done_d[cur_q] = 1'b1;
                    state_d       = S_FINISH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FINISH: begin
                busy_d[cur_q] = 1'b0;
                last_d        = cur_q;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            for (int i = 0; i < NUM_CH; i++) begin
                desc_q[i] <= '0;
            end
            pend_q     <= '0;
            busy_q     <= '0;
            done_q     <= '0;
            err_q      <= '0;
            reject_q   <= '0;
            err_info_q <= '0;
            err_ch_q   <= '0;
            timeout_q  <= 1'b0;
            dma_go_q   <= 1'b0;
            dma_desc_q <= '0;
            last_q     <= CH_MAX;
            cur_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            reject_q   <= reject_d;
            err_info_q <= err_info_d;
            err_ch_q   <= err_ch_d;
            timeout_q  <= timeout_d;
            dma_go_q   <= dma_go_d;
            dma_desc_q <= dma_desc_d;
            last_q     <= last_d;
            cur_q      <= cur_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ch_pend_o   = pend_q;
    assign ch_busy_o   = busy_q;
    assign ch_done_o   = done_q;
    assign ch_err_o    = err_q;
    assign ch_reject_o = reject_q;
    assign err_info_o  = err_info_q;
    assign err_ch_o    = err_ch_q;
    assign timeout_o   = timeout_q;
    assign dma_go_o    = dma_go_q;
    assign dma_desc_o  = dma_desc_q;

endmodule
